// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC phase/frequency path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cordic_pkg;

  // Default phase width; binary angle where -2^(PHASE_W-1) represents -pi.
  localparam int PHASE_W = 32;

  typedef logic signed [PHASE_W-1:0] phase_t;

  // IDLE: no previous phase held yet; ACC: differences are being produced.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } fe_state_t;

  // Binary-angle code for pi (the wrap point of the phase circle).
  localparam logic [PHASE_W-1:0] PI_BAM = {1'b1, {(PHASE_W-1){1'b0}}};

endpackage

// File: rtl/phase_unwrap_diff.sv
// Holds the previous phase and emits the wrapped phase step of each new sample.
// Latency: diff_o/diff_valid_o are combinational from phase_i; prev phase updates on the edge.
// Backpressure: none, every valid sample is accepted.
module phase_unwrap_diff
  import cordic_pkg::*;
#(
  parameter int W = PHASE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                phase_valid_i,
  input  logic signed [W-1:0] phase_i,
  output logic signed [W-1:0] diff_o,
  output logic                diff_valid_o
);

  fe_state_t           state_q, state_d;
  logic signed [W-1:0] prev_q, prev_d;

  // Modular subtraction in W bits gives the shortest signed step across +/-pi.
  assign diff_o = phase_i - prev_q;

  // State register and previous-phase store.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // Next-state: first sample only primes prev_q; later samples yield a difference.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    diff_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (phase_valid_i) begin
          prev_d  = phase_i;
          state_d = ACC;
        end
      end
      ACC: begin
        if (phase_valid_i) begin
          prev_d       = phase_i;
          diff_valid_o = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/cordic_freq_est.sv
// Averages 2^LOG2_N wrapped phase steps into a frequency estimate; FREQ_ROUND_EN selects round-half-up.
// Latency: result registered 1 cycle after the window's last difference is accepted.
// Backpressure: none upstream; an unconsumed result is overwritten and flags sticky overrun.
module cordic_freq_est
  import cordic_pkg::*;
#(
  parameter int PHASE_W = cordic_pkg::PHASE_W,
  parameter int LOG2_N  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      phase_valid,
  input  logic signed [PHASE_W-1:0] phase,
  output logic                      freq_valid,
  input  logic                      freq_ready,
  output logic signed [PHASE_W-1:0] freq,
  output logic                      overrun
);

  localparam int ACC_W = PHASE_W + LOG2_N;
  localparam int CNT_W = (LOG2_N > 0) ? LOG2_N : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_N) - 1);

  logic signed [PHASE_W-1:0] diff;
  logic                      diff_valid;
  logic signed [ACC_W-1:0]   diff_ext, sum;
  logic signed [PHASE_W-1:0] freq_nxt;
  logic                      win_done;

  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [PHASE_W-1:0] freq_q, freq_d;
  logic                      freq_valid_q, freq_valid_d;
  logic                      overrun_q, overrun_d;

  phase_unwrap_diff #(.W(PHASE_W)) u_diff (
    .clk          (clk),
    .rst          (rst),
    .phase_valid_i(phase_valid),
    .phase_i      (phase),
    .diff_o       (diff),
    .diff_valid_o (diff_valid)
  );

  // The accumulator is wide enough for 2^LOG2_N full-scale steps, so no overflow.
  assign diff_ext = ACC_W'(diff);
  assign sum      = acc_q + diff_ext;
  assign win_done = diff_valid && (cnt_q == CNT_LAST);

`ifdef FREQ_ROUND_EN
  // Half an LSB of the output is added before the shift; one spare bit absorbs the carry.
  localparam logic signed [ACC_W:0] RND = (ACC_W+1)'((1 << LOG2_N) >> 1);
  logic signed [ACC_W:0] sum_r;
  assign sum_r    = (ACC_W+1)'(sum) + RND;
  assign freq_nxt = PHASE_W'(sum_r >>> LOG2_N);
`else
  assign freq_nxt = PHASE_W'(sum >>> LOG2_N);
`endif

  // Accumulator, window counter and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  // Accumulate every difference; a completing window loads the output regardless of ready.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    freq_d       = freq_q;
    freq_valid_d = freq_valid_q;
    overrun_d    = overrun_q;
    if (diff_valid) begin
      if (win_done) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    if (freq_valid_q && freq_ready) freq_valid_d = 1'b0;
    if (win_done) begin
      freq_d       = freq_nxt;
      freq_valid_d = 1'b1;
      if (freq_valid_q && !freq_ready) overrun_d = 1'b1;
    end
  end

  assign freq_valid = freq_valid_q;
  assign freq       = freq_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_cordic_freq_est.sv
// Bench for cordic_freq_est: four instances (LOG2_N = 0..3) share one stimulus stream.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: freq_ready driven by the bench per scenario.
module tb_cordic_freq_est;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv  = 1'b0;
  logic [31:0] ph  = '0;
  logic        rdy = 1'b1;

  logic        fv [4];
  logic [31:0] fq [4];
  logic        ov [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_freq_est #(.PHASE_W(32), .LOG2_N(0)) dut0 (
    .clk(clk), .rst(rst), .phase_valid(pv), .phase(ph), .freq_valid(fv[0]),
    .freq_ready(rdy), .freq(fq[0]), .overrun(ov[0]));
  cordic_freq_est #(.PHASE_W(32), .LOG2_N(1)) dut1 (
    .clk(clk), .rst(rst), .phase_valid(pv), .phase(ph), .freq_valid(fv[1]),
    .freq_ready(rdy), .freq(fq[1]), .overrun(ov[1]));
  cordic_freq_est #(.PHASE_W(32), .LOG2_N(2)) dut2 (
    .clk(clk), .rst(rst), .phase_valid(pv), .phase(ph), .freq_valid(fv[2]),
    .freq_ready(rdy), .freq(fq[2]), .overrun(ov[2]));
  cordic_freq_est #(.PHASE_W(32), .LOG2_N(3)) dut3 (
    .clk(clk), .rst(rst), .phase_valid(pv), .phase(ph), .freq_valid(fv[3]),
    .freq_ready(rdy), .freq(fq[3]), .overrun(ov[3]));

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [31:0] p);
    pv = 1'b1;
    ph = p;
    tick();
  endtask

  task automatic idle();
    pv = 1'b0;
    ph = $urandom;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pv  = 1'b0;
    rdy = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Mean of a window: floor(sum / 2^l), or floor((sum + 2^l/2) / 2^l) when rounding.
  function automatic logic [31:0] mean(input longint s, input int l);
    longint n, t, q;
    n = longint'(1) << l;
    t = s;
`ifdef FREQ_ROUND_EN
    t = t + (n / 2);
`endif
    q = t / n;
    if ((t % n) != 0 && t < 0) q = q - 1;
    return q[31:0];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    pv  = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (fv[k] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d] got=%b exp=0", k, fv[k]); end
      total++; if (fq[k] !== 32'h0) begin bad++; $display("FAIL reset_freq[%0d] got=%h exp=0", k, fq[k]); end
      total++; if (ov[k] !== 1'b0) begin bad++; $display("FAIL reset_overrun[%0d] got=%b exp=0", k, ov[k]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_const_step();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      sample(32'(i) * 32'h0100_0000);
      if (i < 4) begin
        total++; if (fv[2] !== 1'b0) begin bad++; $display("FAIL const_early_valid i=%0d got=%b exp=0", i, fv[2]); end
      end
    end
    total++; if (fv[2] !== 1'b1) begin bad++; $display("FAIL const_valid got=%b exp=1", fv[2]); end
    total++; if (fq[2] !== 32'h0100_0000) begin bad++; $display("FAIL const_freq got=%h exp=01000000", fq[2]); end
    idle();
    total++; if (fv[2] !== 1'b0) begin bad++; $display("FAIL const_pulse_end got=%b exp=0", fv[2]); end
  endtask

  task automatic test_wrap();
    logic [31:0] seq [5];
    seq[0] = 32'h7F00_0000; seq[1] = 32'h8100_0000; seq[2] = 32'h8300_0000;
    seq[3] = 32'h8500_0000; seq[4] = 32'h8700_0000;
    do_reset();
    for (int i = 0; i < 5; i++) sample(seq[i]);
    total++; if (fv[2] !== 1'b1 || fq[2] !== 32'h0200_0000) begin
      bad++; $display("FAIL wrap_fwd got=%b/%h exp=1/02000000", fv[2], fq[2]); end
    do_reset();
    for (int i = 4; i >= 0; i--) sample(seq[i]);
    total++; if (fv[2] !== 1'b1 || fq[2] !== 32'hFE00_0000) begin
      bad++; $display("FAIL wrap_rev got=%b/%h exp=1/fe000000", fv[2], fq[2]); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) sample(32'(i) * 32'h100);
    total++; if (fv[2] !== 1'b1 || fq[2] !== 32'h100) begin
      bad++; $display("FAIL bp_first got=%b/%h exp=1/00000100", fv[2], fq[2]); end
    for (int i = 1; i <= 3; i++) begin
      sample(32'h400 + 32'(i) * 32'h200);
      total++; if (fv[2] !== 1'b1 || fq[2] !== 32'h100) begin
        bad++; $display("FAIL bp_hold i=%0d got=%b/%h exp=1/00000100", i, fv[2], fq[2]); end
    end
    total++; if (ov[2] !== 1'b0) begin bad++; $display("FAIL bp_no_early_overrun got=%b exp=0", ov[2]); end
    sample(32'hC00);
    total++; if (fv[2] !== 1'b1 || fq[2] !== 32'h200) begin
      bad++; $display("FAIL bp_second got=%b/%h exp=1/00000200", fv[2], fq[2]); end
    total++; if (ov[2] !== 1'b1) begin bad++; $display("FAIL bp_overrun_set got=%b exp=1", ov[2]); end
    rdy = 1'b1;
    idle();
    total++; if (fv[2] !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b exp=0", fv[2]); end
    idle();
    total++; if (ov[2] !== 1'b1) begin bad++; $display("FAIL bp_overrun_sticky got=%b exp=1", ov[2]); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) sample(32'(i) * 32'h100);
    for (int i = 1; i <= 3; i++) sample(32'h400 + 32'(i) * 32'h300);
    rdy = 1'b1;
    sample(32'h1000);
    total++; if (fv[2] !== 1'b1 || fq[2] !== 32'h300) begin
      bad++; $display("FAIL b2b_load got=%b/%h exp=1/00000300", fv[2], fq[2]); end
    total++; if (ov[2] !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", ov[2]); end
    idle();
    total++; if (fv[2] !== 1'b0 || ov[2] !== 1'b0) begin
      bad++; $display("FAIL b2b_after got=%b/%b exp=0/0", fv[2], ov[2]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) sample(32'(i) * 32'h10);
    rst = 1'b1;
    pv  = 1'b0;
    tick();
    total++; if (fv[2] !== 1'b0 || fq[2] !== 32'h0 || ov[2] !== 1'b0) begin
      bad++; $display("FAIL midrst_during got=%b/%h/%b exp=0/0/0", fv[2], fq[2], ov[2]); end
    rst = 1'b0;
    idle();
    total++; if (fv[2] !== 1'b0 || fq[2] !== 32'h0 || ov[2] !== 1'b0) begin
      bad++; $display("FAIL midrst_after got=%b/%h/%b exp=0/0/0", fv[2], fq[2], ov[2]); end
    for (int i = 0; i < 5; i++) sample(32'h1000 + 32'(i) * 32'h40);
    total++; if (fv[2] !== 1'b1 || fq[2] !== 32'h40) begin
      bad++; $display("FAIL midrst_freq got=%b/%h exp=1/00000040", fv[2], fq[2]); end
  endtask

  task automatic test_gapped();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sample(32'h5000 + 32'(i) * 32'h1000);
      if (i == 8) begin
        total++; if (fv[3] !== 1'b1 || fq[3] !== 32'h1000) begin
          bad++; $display("FAIL gap_freq got=%b/%h exp=1/00001000", fv[3], fq[3]); end
      end else begin
        idle();
        total++; if (fv[3] !== 1'b0) begin bad++; $display("FAIL gap_early i=%0d got=%b exp=0", i, fv[3]); end
      end
    end
  endtask

  task automatic test_rounding();
    logic [31:0] exp_pos, exp_neg;
`ifdef FREQ_ROUND_EN
    exp_pos = 32'd2;
    exp_neg = 32'hFFFF_FFFF;
`else
    exp_pos = 32'd1;
    exp_neg = 32'hFFFF_FFFE;
`endif
    do_reset();
    sample(32'd0); sample(32'd1); sample(32'd3);
    total++; if (fv[1] !== 1'b1 || fq[1] !== exp_pos) begin
      bad++; $display("FAIL round_pos got=%b/%h exp=1/%h", fv[1], fq[1], exp_pos); end
    do_reset();
    sample(32'd0); sample(32'hFFFF_FFFF); sample(32'hFFFF_FFFD);
    total++; if (fv[1] !== 1'b1 || fq[1] !== exp_neg) begin
      bad++; $display("FAIL round_neg got=%b/%h exp=1/%h", fv[1], fq[1], exp_neg); end
  endtask

  task automatic test_random();
    logic [31:0] m_prev [4];
    bit          m_primed [4];
    longint      m_sum [4];
    int          m_nd [4];
    bit          exp_v [4];
    logic [31:0] exp_f [4];
    bit          v;
    logic [31:0] p;
    int          d;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      m_prev[k] = '0; m_primed[k] = 1'b0; m_sum[k] = 0; m_nd[k] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      p = $urandom;
      for (int k = 0; k < 4; k++) begin
        exp_v[k] = 1'b0;
        exp_f[k] = '0;
        if (v) begin
          if (m_primed[k]) begin
            d = int'(p - m_prev[k]);
            m_sum[k] += longint'(d);
            m_nd[k]++;
            if (m_nd[k] == (1 << k)) begin
              exp_v[k] = 1'b1;
              exp_f[k] = mean(m_sum[k], k);
              m_sum[k] = 0;
              m_nd[k]  = 0;
            end
          end
          m_prev[k]   = p;
          m_primed[k] = 1'b1;
        end
      end
      pv = v;
      ph = p;
      tick();
      for (int k = 0; k < 4; k++) begin
        total++; if (fv[k] !== exp_v[k]) begin
          bad++; $display("FAIL rand_valid[%0d] cyc=%0d got=%b exp=%b", k, cyc, fv[k], exp_v[k]); end
        if (exp_v[k]) begin
          total++; if (fq[k] !== exp_f[k]) begin
            bad++; $display("FAIL rand_freq[%0d] cyc=%0d got=%h exp=%h", k, cyc, fq[k], exp_f[k]); end
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      total++; if (ov[k] !== 1'b0) begin bad++; $display("FAIL rand_overrun[%0d] got=%b exp=0", k, ov[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_const_step();
    test_wrap();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_gapped();
    test_rounding();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
